// File: rtl/sc_fir_pkg.sv
// Shared definitions for the stochastic FIR datapath.
//   N            magnitude bits of a sample; a frame is 2^N bitstream cycles
//   POW2N        bits per stochastic frame
//   sample_t     two's-complement input sample, N+1 bits
//   thresh_t     comparator threshold / random word, N bits
//   sng_state_t  stochastic number generator FSM states
//   LFSR_TAPS    feedback taps of the N-bit maximal Fibonacci LFSR
package sc_fir_pkg;

  localparam int unsigned N     = 12;
  localparam int unsigned POW2N = 1 << N;

  typedef logic [N:0]   sample_t;
  typedef logic [N-1:0] thresh_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sng_state_t;

  // x^12 + x^6 + x^4 + x + 1, taps at stages 12, 6, 4 and 1.
  localparam thresh_t LFSR_TAPS = 12'h829;

  // Last count value of a frame.
  localparam thresh_t CNT_MAX = thresh_t'(POW2N - 1);

endpackage

// File: rtl/sc_debruijn_lfsr.sv
// Full-period (de Bruijn) N-bit sequence generator.
// A maximal Fibonacci LFSR whose feedback is inverted whenever the low N-1
// bits are zero, which splices the all-zero state in between 100..0 and
// 00..1. Every N-bit value then appears exactly once per 2^N enabled steps.
//   clk_i    clock, rising edge
//   rst_ni   asynchronous active-low reset, loads SEED
//   en_i     advance one step on this edge
//   state_o  current generator state
module sc_debruijn_lfsr
  import sc_fir_pkg::*;
#(
  parameter thresh_t SEED = 12'h001
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    en_i,
  output thresh_t state_o
);

  thresh_t state_q, state_d;
  logic    fb;
  logic    zero_ins;

  always_comb begin
    zero_ins = (state_q[N-2:0] == '0);
    fb       = (^(state_q & LFSR_TAPS)) ^ zero_ins;
    state_d  = state_q;
    if (en_i) begin
      state_d = {state_q[N-2:0], fb};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/sc_sng.sv
// Stochastic number generator: turns one two's-complement sample into a
// bipolar stochastic frame of 2^N bits whose count of ones equals the
// offset-binary threshold exactly.
//   clock       bitstream clock, rising edge
//   reset_n     asynchronous active-low reset
//   in          two's-complement sample, -2^N .. 2^N-1
//   load        sample strobe, taken only while ready is high
//   ready       a sample can be accepted on this edge
//   bit_out     registered stochastic bit
//   bit_valid   bit_out belongs to a frame
//   frame_last  marks the final bit of a frame
module sc_sng
  import sc_fir_pkg::*;
#(
  parameter thresh_t SEED = 12'h001
) (
  input  logic    clock,
  input  logic    reset_n,
  input  sample_t in,
  input  logic    load,
  output logic    ready,
  output logic    bit_out,
  output logic    bit_valid,
  output logic    frame_last
);

  sng_state_t state_q, state_d;
  thresh_t    cnt_q, cnt_d;
  thresh_t    thresh_q, thresh_d;
  logic       bit_q, bit_d;
  logic       valid_q, valid_d;
  logic       last_q, last_d;

  thresh_t    rnd;
  logic       run;
  logic       accept;
  logic       cnt_end;

  // The offset value's LSB carries no weight in an N-bit threshold.
  logic       unused_x_lsb;
  assign unused_x_lsb = in[0];

  sc_debruijn_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .en_i    (run),
    .state_o (rnd)
  );

  always_comb begin
    run     = (state_q == RUN);
    cnt_end = (cnt_q == CNT_MAX);
    // High during the cycle whose edge registers the final bit, so a new
    // sample can follow with no idle gap.
    ready   = (state_q == IDLE) || (run && cnt_end);
    accept  = load && ready;

    state_d  = state_q;
    cnt_d    = cnt_q;
    thresh_d = thresh_q;
    bit_d    = 1'b0;
    valid_d  = 1'b0;
    last_d   = 1'b0;

    if (run) begin
      bit_d   = (thresh_q > rnd);
      valid_d = 1'b1;
      last_d  = cnt_end;
      cnt_d   = cnt_q + 1'b1;
      if (cnt_end) begin
        state_d = IDLE;
      end
    end

    if (accept) begin
      // Offset conversion {~sign, magnitude} with the LSB dropped.
      thresh_d = {~in[N], in[N-1:1]};
      cnt_d    = '0;
      state_d  = RUN;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      thresh_q <= '0;
      bit_q    <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      thresh_q <= thresh_d;
      bit_q    <= bit_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
    end
  end

  assign bit_out    = bit_q;
  assign bit_valid  = valid_q;
  assign frame_last = last_q;

endmodule

// File: tb/tb_sc_sng.sv
module tb_sc_sng;
  import sc_fir_pkg::*;

  localparam thresh_t Seed = 12'h001;

  logic    clock     = 1'b0;
  logic    reset_n   = 1'b0;
  logic    load      = 1'b0;
  sample_t in_s      = '0;
  logic    ready;
  logic    bit_out;
  logic    bit_valid;
  logic    frame_last;

  logic    lfsr_en   = 1'b0;
  thresh_t lfsr_state;

  int tests = 0;
  int fails = 0;

  int o_a, o_b, o_v, o_l, o_p, o_r;
  int distinct;
  logic [4095:0] seen;

  sc_sng #(
    .SEED (Seed)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in         (in_s),
    .load       (load),
    .ready      (ready),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .frame_last (frame_last)
  );

  // Standalone generator with the all-zero seed.
  sc_debruijn_lfsr #(
    .SEED (12'h000)
  ) u_lfsr_ref (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .en_i    (lfsr_en),
    .state_o (lfsr_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Presents a sample at a falling edge; the next rising edge accepts it.
  task automatic load_sample(input logic [N:0] v);
    @(negedge clock);
    in_s = v;
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
  endtask

  // Runs ncyc rising edges starting from a falling edge. ready is sampled
  // before each edge and credited to the bit that edge registers. load is
  // pulsed on edge number load_at (0 = never).
  task automatic observe(input int ncyc, input int load_at, input logic [N:0] load_val,
                         output int ones_a, output int ones_b, output int valids,
                         output int lasts, output int last_pos, output int ready_lo);
    logic rdy;
    ones_a   = 0;
    ones_b   = 0;
    valids   = 0;
    lasts    = 0;
    last_pos = -1;
    ready_lo = 0;
    for (int i = 1; i <= ncyc; i++) begin
      if (i == load_at) begin
        in_s = load_val;
        load = 1'b1;
      end
      rdy = ready;
      @(posedge clock);
      #1;
      load = 1'b0;
      if (bit_valid) begin
        valids++;
        if (!rdy) ready_lo++;
        if (lasts == 0) ones_a += int'(bit_out);
        else            ones_b += int'(bit_out);
      end
      if (frame_last) begin
        lasts++;
        if (lasts == 1) last_pos = valids;
      end
      @(negedge clock);
    end
  endtask

  initial begin
    // Reset values.
    repeat (3) @(negedge clock);
    check("rst_ready", int'(ready), 1);
    check("rst_bit_out", int'(bit_out), 0);
    check("rst_bit_valid", int'(bit_valid), 0);
    check("rst_frame_last", int'(frame_last), 0);
    check("rst_r_seed", int'(dut.rnd), int'(Seed));

    // in = 0 loaded on the first edge after reset release: T = 2048.
    reset_n = 1'b1;
    in_s    = 13'h0000;
    load    = 1'b1;
    @(negedge clock);
    load = 1'b0;
    observe(4097, 0, 13'h0000, o_a, o_b, o_v, o_l, o_p, o_r);
    check("in0_ones", o_a, 2048);
    check("in0_valids", o_v, 4096);
    check("in0_lasts", o_l, 1);
    check("in0_last_pos", o_p, 4096);
    check("in0_ready_lo", o_r, 4095);
    check("in0_end_valid", int'(bit_valid), 0);
    check("in0_end_ready", int'(ready), 1);
    check("in0_r_period", int'(dut.rnd), int'(Seed));

    // Extremes: -4096 gives T = 0, 4095 gives T = 4095.
    load_sample(13'h1000);
    observe(4097, 0, 13'h0000, o_a, o_b, o_v, o_l, o_p, o_r);
    check("neg_ones", o_a, 0);
    check("neg_valids", o_v, 4096);
    load_sample(13'h0FFF);
    observe(4097, 0, 13'h0000, o_a, o_b, o_v, o_l, o_p, o_r);
    check("pos_ones", o_a, 4095);
    check("pos_last_pos", o_p, 4096);

    // in = 3: X = 0x1003, T = 0x801.
    load_sample(13'h0003);
    observe(4097, 0, 13'h0000, o_a, o_b, o_v, o_l, o_p, o_r);
    check("in3_ones", o_a, 2049);

    // Back-to-back 3 then 7 (T = 0x803), load held on the final-bit edge.
    load_sample(13'h0003);
    observe(8193, 4096, 13'h0007, o_a, o_b, o_v, o_l, o_p, o_r);
    check("b2b_ones_a", o_a, 2049);
    check("b2b_ones_b", o_b, 2051);
    check("b2b_valids", o_v, 8192);
    check("b2b_lasts", o_l, 2);
    check("b2b_first_last", o_p, 4096);
    check("b2b_ready_lo", o_r, 8190);
    check("b2b_end_valid", int'(bit_valid), 0);

    // load at bit 100 of a frame must be ignored.
    load_sample(13'h0000);
    observe(4097, 100, 13'h1000, o_a, o_b, o_v, o_l, o_p, o_r);
    check("mid_ones", o_a, 2048);
    check("mid_valids", o_v, 4096);
    check("mid_lasts", o_l, 1);
    check("mid_last_pos", o_p, 4096);

    // Asynchronous reset at bit 2000, between clock edges.
    load_sample(13'h0000);
    observe(2000, 0, 13'h0000, o_a, o_b, o_v, o_l, o_p, o_r);
    check("pre_rst_valids", o_v, 2000);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_ready", int'(ready), 1);
    check("arst_bit_out", int'(bit_out), 0);
    check("arst_bit_valid", int'(bit_valid), 0);
    check("arst_frame_last", int'(frame_last), 0);
    check("arst_r_seed", int'(dut.rnd), int'(Seed));
    @(negedge clock);
    reset_n = 1'b1;
    load_sample(13'h0000);
    observe(4097, 0, 13'h0000, o_a, o_b, o_v, o_l, o_p, o_r);
    check("post_rst_ones", o_a, 2048);
    check("post_rst_valids", o_v, 4096);
    check("post_rst_r_period", int'(dut.rnd), int'(Seed));

    // Standalone generator, seed 0: held while disabled, then full period.
    check("lfsr_hold", int'(lfsr_state), 0);
    seen     = '0;
    distinct = 0;
    @(negedge clock);
    lfsr_en = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      if (!seen[lfsr_state]) distinct++;
      seen[lfsr_state] = 1'b1;
      @(negedge clock);
    end
    lfsr_en = 1'b0;
    check("lfsr_distinct", distinct, 4096);
    check("lfsr_return_seed", int'(lfsr_state), 0);
    repeat (3) @(negedge clock);
    check("lfsr_disabled", int'(lfsr_state), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
